// File: rtl/pipe_add.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES carry segments, valid/ready on both sides.
// Build option PIPE_ADD_SUB_EN adds a Sub port (A - B - Cin, Cout = no borrow).
module pipe_add #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef PIPE_ADD_SUB_EN
  input  logic             Sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned SEG = WIDTH / STAGES;

  // Per-stage registers: valid, carry out, operands, partial sum
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] c_r;
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  s_r [STAGES];
  logic              ovf_r;

  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] c_nx;
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [WIDTH-1:0]  s_nx  [STAGES];
  logic [SEG:0]      seg;
  logic              ovf_nx;
  logic              r_acc;

  // Stage inputs, segment adds and the backward ready chain
  always_comb begin
    a_src  = '{default: '0};
    b_src  = '{default: '0};
    s_src  = '{default: '0};
    s_nx   = '{default: '0};
    v_src  = '0;
    c_src  = '0;
    c_nx   = '0;
    seg    = '0;
    rdy    = '0;
    r_acc  = out_ready;
    ovf_nx = 1'b0;

    // Subtraction folds into the add as A + ~B + ~Cin at capture time
    a_src[0] = A;
    b_src[0] = B;
    c_src[0] = Cin;
`ifdef PIPE_ADD_SUB_EN
    if (Sub) begin
      b_src[0] = ~B;
      c_src[0] = ~Cin;
    end
`endif
    v_src[0] = in_valid;
    for (int k = 1; k < int'(STAGES); k++) begin
      a_src[k] = a_r[k-1];
      b_src[k] = b_r[k-1];
      c_src[k] = c_r[k-1];
      s_src[k] = s_r[k-1];
      v_src[k] = v[k-1];
    end

    for (int k = 0; k < int'(STAGES); k++) begin
      seg = {1'b0, a_src[k][k*SEG +: SEG]} + {1'b0, b_src[k][k*SEG +: SEG]}
            + (SEG+1)'(c_src[k]);
      s_nx[k] = s_src[k];
      s_nx[k][k*SEG +: SEG] = seg[SEG-1:0];
      c_nx[k] = seg[SEG];
    end

    ovf_nx = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1]) &&
             (s_nx[STAGES-1][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);

    // A stage can load if it is empty or everything downstream moves
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      r_acc  = !v[k] || r_acc;
      rdy[k] = r_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      c_r   <= '0;
      ovf_r <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (rdy[k]) begin
          v[k] <= v_src[k];
          if (v_src[k]) begin
            a_r[k] <= a_src[k];
            b_r[k] <= b_src[k];
            s_r[k] <= s_nx[k];
            c_r[k] <= c_nx[k];
          end
        end
      end
      if (rdy[STAGES-1] && v_src[STAGES-1]) ovf_r <= ovf_nx;
    end
  end

  assign in_ready  = rdy[0] && !rst;
  assign out_valid = v[STAGES-1];
  assign Sum       = s_r[STAGES-1];
  assign Cout      = c_r[STAGES-1];
  assign Ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_add.sv
// Bench for pipe_add: directed cases plus random traffic against an arithmetic scoreboard,
// and an exhaustive pass on a WIDTH=4/STAGES=2 instance.
module tb_pipe_add;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b, sum;
  logic        cin, sub, in_valid, in_ready, cout, ovf, out_valid, out_ready;
  logic [3:0]  sa, sb, ssum;
  logic        scin, ssub, s_in_valid, s_in_ready, scout, sovf, s_out_valid, s_out_ready;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat;
  bit          chk_lat = 1'b0;
  bit          hold_pend = 1'b0;
  logic [17:0] hold_val;
  logic [17:0] exp_q[$];
  int          cyc_q[$];
  logic [17:0] s_exp_q[$];

  pipe_add #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin),
`ifdef PIPE_ADD_SUB_EN
    .Sub(sub),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .Sum(sum), .Cout(cout), .Ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  pipe_add #(.WIDTH(4), .STAGES(2)) u_small (
    .clk(clk), .rst(rst), .A(sa), .B(sb), .Cin(scin),
`ifdef PIPE_ADD_SUB_EN
    .Sub(ssub),
`endif
    .in_valid(s_in_valid), .in_ready(s_in_ready), .Sum(ssum), .Cout(scout), .Ovf(sovf),
    .out_valid(s_out_valid), .out_ready(s_out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result packed as {cout, ovf, sum}
  function automatic logic [17:0] model(input int w, input longint xa, input longint xb,
                                        input int xc, input int xs);
    longint m, half, x, s, sa_, sb_, sx;
    bit co, ov;
    m    = longint'(1) << w;
    half = m / 2;
    x    = (xs != 0) ? xa - xb - xc : xa + xb + xc;
    s    = ((x % m) + m) % m;
    co   = (xs != 0) ? (xa >= xb + xc) : (x >= m);
    sa_  = (xa >= half) ? xa - m : xa;
    sb_  = (xb >= half) ? xb - m : xb;
    sx   = (xs != 0) ? sa_ - sb_ - xc : sa_ + sb_ + xc;
    ov   = (sx >= half) || (sx < -half);
    return {co, ov, 16'(s)};
  endfunction

  // Scoreboard for the main instance, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && out_valid) chk("hold", 32'({cout, ovf, sum}), 32'(hold_val));
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() < 4) || out_ready));
      if (in_valid && in_ready) begin
        exp_q.push_back(model(16, longint'(a), longint'(b), int'(cin), int'(sub)));
        cyc_q.push_back(cyc + 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else begin
          chk("result", 32'({cout, ovf, sum}), 32'(exp_q.pop_front()));
          lat = cyc + 1 - cyc_q.pop_front();
          if (chk_lat) chk("latency", 32'(lat), 32'd4);
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {cout, ovf, sum};
    end
  end

  // Scoreboard for the small instance
  always @(negedge clk) begin
    if (!rst) begin
      chk("s_in_ready", 32'(s_in_ready), 32'((s_exp_q.size() < 2) || s_out_ready));
      if (s_in_valid && s_in_ready)
        s_exp_q.push_back(model(4, longint'(sa), longint'(sb), int'(scin), int'(ssub)));
      if (s_out_valid && s_out_ready) begin
        if (s_exp_q.size() == 0) chk("s_spurious_out", 32'd1, 32'd0);
        else chk("s_result", 32'({scout, sovf, 12'd0, ssum}), 32'(s_exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                      input logic xs);
    bit ok = 1'b0;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] es, input logic ec,
                            input logic eo);
    bit ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({tag, "_sum"}, 32'(sum), 32'(es));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("drain_empty", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    bit ok;
    rst = 1'b1; a = '0; b = '0; cin = 0; sub = 0; in_valid = 0; out_ready = 1;
    sa = '0; sb = '0; scin = 0; ssub = 0; s_in_valid = 0; s_out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);

    // Wrap-around and full-length carry ripple, with latency checked
    chk_lat = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    expect_out("t1", 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    expect_out("t2", 16'h8000, 1'b0, 1'b1);

    // Back-to-back stream: every result exactly four edges after acceptance
    for (int i = 0; i < 8; i++) send(16'(i), 16'(i * 4096), i[0], 1'b0);
    drain();
    chk_lat = 1'b0;

    // Backpressure: pipeline fills to four, then stalls input
    out_ready = 1'b0; in_valid = 1'b1; cnt = 0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    repeat (6) begin
      @(negedge clk);
      if (in_ready) cnt++;
      @(posedge clk); #1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    end
    in_valid = 1'b0;
    chk("full_accepts", 32'(cnt), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drain();

    // Reset with three transactions in flight
    out_ready = 1'b0;
    repeat (3) send(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete(); cyc_q.delete(); s_exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("rel2_in_ready", 32'(in_ready), 32'd1);
    chk("rel2_out_valid", 32'(out_valid), 32'd0);
    repeat (8) begin
      @(negedge clk);
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

`ifdef PIPE_ADD_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    expect_out("t6a", 16'hFFFE, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    expect_out("t6b", 16'h7FFF, 1'b1, 1'b1);
`endif

    // Random traffic with random stalls on both sides
    for (int i = 0; i < 1500; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef PIPE_ADD_SUB_EN
      sub = 1'($urandom);
`endif
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; sub = 1'b0;
    drain();

    // Small instance: every A, B, Cin combination with random downstream stalls
    for (int vi = 0; vi < 512; vi++) begin
      sa = 4'(vi); sb = 4'(vi >> 4); scin = 1'(vi >> 8); s_in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (s_in_ready) begin ok = 1'b1; break; end
        @(posedge clk); #1;
        s_out_ready = 1'($urandom);
      end
      if (!ok) chk("s_send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      s_out_ready = 1'($urandom);
      s_in_valid = 1'b0;
    end
    s_out_ready = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (s_exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("s_drain_empty", 32'(ok), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
